conv_c1_ctrl: RTL and testbench
===============================

// Module: conv_c1_ctrl
// PURPOSE
// Sequencer for the C1 convolution datapath (conv_in1 array, 1 input map -> OUTPUT_NUM maps).
// Scans every output pixel of a KxK valid convolution and issues one tap per cycle.
// Per tap: drives image/weight buffer read addresses, and the aa_en/aa_first_data/aa_last_data
// framing aligned to read data; counts datapath results and generates output-buffer write addresses.
// PARAMETERS
// IMG_W   32  input map width (pixels)
// IMG_H   32  input map height
// K       5   kernel size (K*K taps per output pixel)
// RD_LAT  1   image/weight buffer read latency (cycles, >=1)
// AW      10  image read address width (>= clog2(IMG_W*IMG_H))
// WAW     5   weight read address width (>= clog2(K*K)); one word = all OUTPUT_NUM kernels' tap
// OAW     10  output write address width (>= clog2(OW*OH)); OW=IMG_W-K+1, OH=IMG_H-K+1
// PORTS
// clk            in   1    clock
// rst_n          in   1    reset, asynchronous, active-low
// start          in   1    start one full map; sampled only in IDLE
// abort          in   1    synchronous clear to IDLE, highest priority after rst_n
// busy           out  1    high in ISSUE and DRAIN
// done           out  1    one-cycle pulse when last result written
// img_rd_en      out  1    image buffer read strobe
// img_rd_addr    out  AW   (oy+ky)*IMG_W + (ox+kx)
// w_rd_en        out  1    weight buffer read strobe (same cycle as img_rd_en)
// w_rd_addr      out  WAW  ky*K + kx
// aa_en          out  1    tap valid to datapath, img_rd_en delayed RD_LAT
// aa_first_data  out  1    tap 0 of a pixel, delayed RD_LAT
// aa_last_data   out  1    tap K*K-1 of a pixel, delayed RD_LAT
// conv_q_en      in   1    datapath result valid (q_en of conv_in1)
// out_wr_en      out  1    = conv_q_en while busy (combinational pass)
// out_wr_addr    out  OAW  oy*OW+ox of the result being written, starts at 0
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; all counters and delay pipes 0.
// - FSM: IDLE -start-> ISSUE; ISSUE -last tap of last pixel issued-> DRAIN;
//   DRAIN -result count reaches OW*OH-> DONE; DONE -> IDLE (done=1 for that cycle only).
//   If the final result arrives while still in ISSUE (not possible with latency>=1) DRAIN still entered, exits next cycle.
// - start while busy or in DONE ignored. abort: state IDLE, counters/pipes cleared, no done pulse,
//   conv_q_en ignored from the next cycle.
// - ISSUE: one tap per cycle, no bubbles, including across pixel boundaries. Loop order (inner->outer):
//   kx, ky, ox, oy. Total issue cycles = OW*OH*K*K (C1 default 19600).
// - Addresses computed incrementally (row-base register + offsets), no multipliers; img_rd_addr never
//   exceeds IMG_W*IMG_H-1; wrap of kx at K-1, ky at K-1, ox at OW-1, oy at OH-1 all reset to 0.
// - Framing: first/last flags generated at issue and shifted through an RD_LAT-deep pipe together with
//   en, so aa_* are asserted in the cycle the read data is valid; aa_first_data/aa_last_data never high
//   when aa_en low. For K=1 first and last are high on the same tap.
// - Output: result counter increments on each out_wr_en; out_wr_addr = counter value before increment.
//   conv_q_en outside busy ignored (no write, no count).
// STRUCTURE
// - Shared package: state enum (IDLE, ISSUE, DRAIN, DONE), localparams OW, OH, TAPS=K*K, NPIX=OW*OH.
// - One sub-module natural: conv_tap_dly (RD_LAT-deep shift register for {en,first,last}, clears on abort).
// TESTING
// - C1 default, start once: 19600 issue cycles; first addrs img 0/w 0, tap 24 of pixel 0 img 132/w 24;
//   aa_en first high exactly RD_LAT cycles after first img_rd_en; done once after 784 writes, out_wr_addr 0..783.
// - IMG_W=IMG_H=6,K=3: 16 pixels x 9 taps = 144 issue cycles; pixel (ox=3,oy=3) tap 8 -> img_rd_addr 35, w 8.
// - Back-to-back pixels: aa_last_data of pixel n immediately followed next cycle by aa_first_data of n+1, aa_en continuous.
// - start pulsed during ISSUE and DRAIN -> no restart, addresses undisturbed; start in DONE cycle ignored.
// - abort at issue cycle 500 -> busy=0 next cycle, all outputs 0, no done; new start -> addresses restart from 0.
// - RD_LAT=3 and K=1 configs: aa_* delayed 3 cycles; first=last=1 on every tap; conv_q_en injected in IDLE -> no write.

Source files
------------

// File: rtl/conv_c1_ctrl_pkg.sv
// Shared types and default C1 geometry for the C1 convolution sequencer.
package conv_c1_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Default C1 geometry: 32x32 input map, 5x5 kernel.
  localparam int unsigned C1_IMG_W = 32;
  localparam int unsigned C1_IMG_H = 32;
  localparam int unsigned C1_K     = 5;
  localparam int unsigned OW       = C1_IMG_W - C1_K + 1;
  localparam int unsigned OH       = C1_IMG_H - C1_K + 1;
  localparam int unsigned TAPS     = C1_K * C1_K;
  localparam int unsigned NPIX     = OW * OH;

  // Output dimension of a valid convolution.
  function automatic int unsigned out_dim(input int unsigned img, input int unsigned k);
    return img - k + 1;
  endfunction

endpackage

// File: rtl/conv_c1_ctrl_if.sv
// Control, buffer-read and result-write signals of the C1 sequencer.
interface conv_c1_ctrl_if #(
  parameter int unsigned AW  = 10,
  parameter int unsigned WAW = 5,
  parameter int unsigned OAW = 10
);
  logic           start;
  logic           abort;
  logic           busy;
  logic           done;
  logic           img_rd_en;
  logic [AW-1:0]  img_rd_addr;
  logic           w_rd_en;
  logic [WAW-1:0] w_rd_addr;
  logic           aa_en;
  logic           aa_first_data;
  logic           aa_last_data;
  logic           conv_q_en;
  logic           out_wr_en;
  logic [OAW-1:0] out_wr_addr;

  // Sequencer side.
  modport master (
    input  start, abort, conv_q_en,
    output busy, done, img_rd_en, img_rd_addr, w_rd_en, w_rd_addr,
           aa_en, aa_first_data, aa_last_data, out_wr_en, out_wr_addr
  );

  // Environment side (control, buffers, datapath).
  modport slave (
    output start, abort, conv_q_en,
    input  busy, done, img_rd_en, img_rd_addr, w_rd_en, w_rd_addr,
           aa_en, aa_first_data, aa_last_data, out_wr_en, out_wr_addr
  );
endinterface

// File: rtl/conv_c1_ctrl_tap_dly.sv
// RD_LAT-deep shift register aligning tap framing with buffer read data.
module conv_tap_dly #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned W      = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic [W-1:0] i_tap,
  output logic [W-1:0] o_tap
);

  logic [W-1:0] r_pipe [RD_LAT];

  // Shift framing one stage per cycle; abort flushes every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
    end else if (i_clr) begin
      for (int unsigned i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_tap;
      for (int unsigned i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_tap = r_pipe[RD_LAT-1];

endmodule

// File: rtl/conv_c1_ctrl.sv
// C1 convolution sequencer: scans every output pixel, issues one kernel tap per
// cycle to the image/weight buffers and counts datapath results into the output buffer.
module conv_c1_ctrl
  import conv_c1_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned K      = 5,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned AW     = 10,
  parameter int unsigned WAW    = 5,
  parameter int unsigned OAW    = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  conv_c1_ctrl_if.master bus
);

  localparam int unsigned MAP_OW   = out_dim(IMG_W, K);
  localparam int unsigned MAP_OH   = out_dim(IMG_H, K);
  localparam int unsigned MAP_NPIX = MAP_OW * MAP_OH;

  localparam logic [AW-1:0]  ROW_STEP = AW'(IMG_W);
  localparam logic [AW-1:0]  K_LAST   = AW'(K - 1);
  localparam logic [AW-1:0]  OX_LAST  = AW'(MAP_OW - 1);
  localparam logic [AW-1:0]  OY_LAST  = AW'(MAP_OH - 1);
  localparam logic [OAW:0]   RES_ALL  = (OAW+1)'(MAP_NPIX);

  state_t         r_state, w_state_nxt;
  logic           w_issue, w_busy, w_done;

  // Scan counters; r_row_base = oy*IMG_W and r_krow = ky*IMG_W kept incrementally.
  logic [AW-1:0]  r_kx, r_ky, r_ox, r_oy, r_krow, r_row_base;
  logic [WAW-1:0] r_wa;
  logic           w_kx_end, w_ky_end, w_ox_end, w_oy_end, w_tap_last, w_last_issue;
  logic [AW-1:0]  w_img_addr;

  logic [OAW:0]   r_res_cnt, w_res_nxt;
  logic           w_wr;

  logic [2:0]     w_tap_in, w_tap_out;

  assign w_kx_end     = (r_kx == K_LAST);
  assign w_ky_end     = (r_ky == K_LAST);
  assign w_ox_end     = (r_ox == OX_LAST);
  assign w_oy_end     = (r_oy == OY_LAST);
  assign w_tap_last   = w_kx_end & w_ky_end;
  assign w_last_issue = w_tap_last & w_ox_end & w_oy_end;
  assign w_img_addr   = r_row_base + r_krow + r_ox + r_kx;

  assign w_wr      = bus.conv_q_en & w_busy;
  assign w_res_nxt = r_res_cnt + {{OAW{1'b0}}, w_wr};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and status decode; abort overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_issue = 1'b1;
        w_busy  = 1'b1;
        if (w_last_issue) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_busy = 1'b1;
        if (w_res_nxt >= RES_ALL) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (bus.abort) w_state_nxt = ST_IDLE;
  end

  // Tap scan, kx innermost then ky, ox, oy; every counter returns to 0 on wrap,
  // so all of them sit at 0 outside ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kx <= '0; r_ky <= '0; r_ox <= '0; r_oy <= '0;
      r_krow <= '0; r_row_base <= '0; r_wa <= '0;
    end else if (bus.abort) begin
      r_kx <= '0; r_ky <= '0; r_ox <= '0; r_oy <= '0;
      r_krow <= '0; r_row_base <= '0; r_wa <= '0;
    end else if (w_issue) begin
      if (!w_kx_end) begin
        r_kx <= r_kx + 1'b1;
        r_wa <= r_wa + 1'b1;
      end else begin
        r_kx <= '0;
        if (!w_ky_end) begin
          r_ky   <= r_ky + 1'b1;
          r_krow <= r_krow + ROW_STEP;
          r_wa   <= r_wa + 1'b1;
        end else begin
          r_ky   <= '0;
          r_krow <= '0;
          r_wa   <= '0;
          if (!w_ox_end) begin
            r_ox <= r_ox + 1'b1;
          end else begin
            r_ox <= '0;
            if (!w_oy_end) begin
              r_oy       <= r_oy + 1'b1;
              r_row_base <= r_row_base + ROW_STEP;
            end else begin
              r_oy       <= '0;
              r_row_base <= '0;
            end
          end
        end
      end
    end
  end

  // Result counter; cleared while DONE so the next map writes from address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_res_cnt <= '0;
    else if (bus.abort || r_state == ST_DONE) r_res_cnt <= '0;
    else if (w_wr)                            r_res_cnt <= w_res_nxt;
  end

  assign w_tap_in = {w_issue,
                     w_issue & (r_kx == '0) & (r_ky == '0),
                     w_issue & w_tap_last};

  conv_tap_dly #(
    .RD_LAT (RD_LAT),
    .W      (3)
  ) u_tap_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (bus.abort),
    .i_tap (w_tap_in),
    .o_tap (w_tap_out)
  );

  assign bus.busy          = w_busy;
  assign bus.done          = w_done;
  assign bus.img_rd_en     = w_issue;
  assign bus.img_rd_addr   = w_issue ? w_img_addr : '0;
  assign bus.w_rd_en       = w_issue;
  assign bus.w_rd_addr     = w_issue ? r_wa : '0;
  assign bus.aa_en         = w_tap_out[2];
  assign bus.aa_first_data = w_tap_out[2] & w_tap_out[1];
  assign bus.aa_last_data  = w_tap_out[2] & w_tap_out[0];
  assign bus.out_wr_en     = w_wr;
  assign bus.out_wr_addr   = r_res_cnt[OAW-1:0];

endmodule

// File: tb/tb_conv_c1_ctrl.sv
// Bench for conv_c1_ctrl: three configurations (C1 default, 6x6 K=3, 4x4 K=1 RD_LAT=3)
// compared every cycle against a tap-index reference model, plus address spot vectors.
module tb_conv_c1_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_c1_ctrl_if #(.AW(10), .WAW(5), .OAW(10)) bus0 ();
  conv_c1_ctrl_if #(.AW(10), .WAW(5), .OAW(10)) bus1 ();
  conv_c1_ctrl_if #(.AW(10), .WAW(5), .OAW(10)) bus2 ();

  conv_c1_ctrl #(.IMG_W(32), .IMG_H(32), .K(5), .RD_LAT(1), .AW(10), .WAW(5), .OAW(10))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  conv_c1_ctrl #(.IMG_W(6), .IMG_H(6), .K(3), .RD_LAT(1), .AW(10), .WAW(5), .OAW(10))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  conv_c1_ctrl #(.IMG_W(4), .IMG_H(4), .K(1), .RD_LAT(3), .AW(10), .WAW(5), .OAW(10))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int cw   [3] = '{32, 6, 4};
  int ch   [3] = '{32, 6, 4};
  int ck   [3] = '{5, 3, 1};
  int clat [3] = '{1, 1, 3};

  logic [2:0] start_v, abort_v, qen_v;
  assign bus0.start = start_v[0]; assign bus0.abort = abort_v[0]; assign bus0.conv_q_en = qen_v[0];
  assign bus1.start = start_v[1]; assign bus1.abort = abort_v[1]; assign bus1.conv_q_en = qen_v[1];
  assign bus2.start = start_v[2]; assign bus2.abort = abort_v[2]; assign bus2.conv_q_en = qen_v[2];

  typedef struct packed {
    logic       busy, done, img_en;
    logic [9:0] img_addr;
    logic       w_en;
    logic [4:0] w_addr;
    logic       aa_en, aa_f, aa_l, wr_en;
    logic [9:0] wr_addr;
  } obs_t;

  obs_t o0, o1, o2, m;
  assign o0 = {bus0.busy, bus0.done, bus0.img_rd_en, bus0.img_rd_addr, bus0.w_rd_en, bus0.w_rd_addr,
               bus0.aa_en, bus0.aa_first_data, bus0.aa_last_data, bus0.out_wr_en, bus0.out_wr_addr};
  assign o1 = {bus1.busy, bus1.done, bus1.img_rd_en, bus1.img_rd_addr, bus1.w_rd_en, bus1.w_rd_addr,
               bus1.aa_en, bus1.aa_first_data, bus1.aa_last_data, bus1.out_wr_en, bus1.out_wr_addr};
  assign o2 = {bus2.busy, bus2.done, bus2.img_rd_en, bus2.img_rd_addr, bus2.w_rd_en, bus2.w_rd_addr,
               bus2.aa_en, bus2.aa_first_data, bus2.aa_last_data, bus2.out_wr_en, bus2.out_wr_addr};

  int sel;
  assign m = (sel == 0) ? o0 : (sel == 1) ? o1 : o2;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: phase 0 idle, 1 issuing, 2 draining, 3 done cycle.
  int         m_phase, m_iss, m_res;
  logic [2:0] hist[$];
  bit         dpq[$];
  bit         qen_next;
  int         dp_lat;
  bit         inject;

  int n_iss, n_done, n_wr;
  int cap_img [int];
  int cap_w   [int];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_phase = 0; m_iss = 0; m_res = 0;
    hist.delete();
    for (int i = 0; i < clat[sel]; i++) hist.push_back(3'b000);
    dpq.delete();
    for (int i = 0; i < dp_lat; i++) dpq.push_back(1'b0);
    qen_next = 1'b0;
  endfunction

  // Per-cycle comparison against the model, then model advance for the coming edge.
  always @(negedge clk) begin
    int ow, kk, taps, npix, total, tap, pix, ox, oy, kx, ky;
    int issuing, e_img, e_w, e_busy, e_done, e_wr;
    logic [2:0] e_aa;
    logic st, ab, q;
    ow = cw[sel] - ck[sel] + 1;
    kk = ck[sel];
    taps = kk * kk;
    npix = ow * (ch[sel] - ck[sel] + 1);
    total = npix * taps;
    if (!rst_n) begin
      chk("reset_outputs_zero", (m == '0) ? 1 : 0, 1);
      model_clear();
    end else begin
      issuing = (m_phase == 1) ? 1 : 0;
      tap = m_iss % taps; pix = m_iss / taps;
      ox = pix % ow; oy = pix / ow; kx = tap % kk; ky = tap / kk;
      e_img  = (issuing != 0) ? (oy + ky) * cw[sel] + ox + kx : 0;
      e_w    = (issuing != 0) ? ky * kk + kx : 0;
      e_busy = (m_phase == 1 || m_phase == 2) ? 1 : 0;
      e_done = (m_phase == 3) ? 1 : 0;
      e_aa   = hist[0];
      st = start_v[sel]; ab = abort_v[sel]; q = qen_v[sel];
      e_wr = (q && e_busy != 0) ? 1 : 0;

      chk("busy",          int'(m.busy),     e_busy);
      chk("done",          int'(m.done),     e_done);
      chk("img_rd_en",     int'(m.img_en),   issuing);
      chk("img_rd_addr",   int'(m.img_addr), e_img);
      chk("w_rd_en",       int'(m.w_en),     issuing);
      chk("w_rd_addr",     int'(m.w_addr),   e_w);
      chk("aa_en",         int'(m.aa_en),    int'(e_aa[2]));
      chk("aa_first_data", int'(m.aa_f),     int'(e_aa[1]));
      chk("aa_last_data",  int'(m.aa_l),     int'(e_aa[0]));
      chk("out_wr_en",     int'(m.wr_en),    e_wr);
      if (e_busy != 0) chk("out_wr_addr", int'(m.wr_addr), m_res);

      if (m.img_en) begin
        cap_img[sel * 100000 + n_iss] = int'(m.img_addr);
        cap_w[sel * 100000 + n_iss]   = int'(m.w_addr);
        n_iss++;
      end
      if (m.done)  n_done++;
      if (m.wr_en) n_wr++;

      dpq.push_back(m.aa_l);
      qen_next = dpq.pop_front();
      hist.push_back({issuing != 0, issuing != 0 && tap == 0, issuing != 0 && tap == taps - 1});
      void'(hist.pop_front());

      if (ab) model_clear();
      else begin
        case (m_phase)
          0: if (st) begin m_phase = 1; m_iss = 0; m_res = 0; end
          1: begin
               if (e_wr != 0) m_res++;
               m_iss++;
               if (m_iss == total) m_phase = 2;
             end
          2: begin
               if (e_wr != 0) m_res++;
               if (m_res >= npix) m_phase = 3;
             end
          default: m_phase = 0;
        endcase
      end
    end
  end

  // Datapath stand-in: one result per finished pixel, dp_lat cycles later.
  always @(posedge clk) begin
    #1;
    qen_v = '0;
    qen_v[sel] = qen_next | inject;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic select_cfg(input int n);
    sel = n;
    dp_lat = int'($urandom_range(1, 4));
    model_clear();
  endtask

  task automatic run_full(input int noise);
    int npix, total;
    bit got;
    npix = (cw[sel] - ck[sel] + 1) * (ch[sel] - ck[sel] + 1);
    total = npix * ck[sel] * ck[sel];
    n_iss = 0; n_done = 0; n_wr = 0;
    start_v[sel] = 1'b1;
    tick();
    start_v[sel] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < total + 200 && !got; i++) begin
      tick();
      // start during the DONE cycle, and random start pulses while busy, must be ignored
      start_v[sel] = (m_phase == 3) ||
                     (noise != 0 && (m_phase == 1 || m_phase == 2) && $urandom_range(0, 99) < 3);
      if (n_done > 0 && m_phase == 0) got = 1'b1;
    end
    start_v[sel] = 1'b0;
    chk("run_completed_in_budget", int'(got), 1);
    repeat (6) tick();
    chk("done_pulse_count", n_done, 1);
    chk("issue_cycle_count", n_iss, total);
    chk("result_write_count", n_wr, npix);
  endtask

  typedef struct {
    int cfg;
    int t;
    int img;
    int w;
  } vec_t;

  vec_t vtab [9];

  initial begin
    bit found;
    vtab[0] = '{0, 0,     0,    0};
    vtab[1] = '{0, 24,    132,  24};
    vtab[2] = '{0, 25,    1,    0};
    vtab[3] = '{0, 19599, 1023, 24};
    vtab[4] = '{1, 0,     0,    0};
    vtab[5] = '{1, 17,    15,   8};
    vtab[6] = '{1, 143,   35,   8};
    vtab[7] = '{2, 5,     5,    0};
    vtab[8] = '{2, 15,    15,   0};

    rst_n = 1'b0; start_v = '0; abort_v = '0; inject = 1'b0; qen_next = 1'b0;
    select_cfg(0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // C1: abort while issuing tap 500, then a full map from scratch
    n_iss = 0; n_done = 0; n_wr = 0;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      tick();
      if (m_phase == 1 && m_iss == 500) found = 1'b1;
    end
    chk("abort_point_reached", int'(found), 1);
    abort_v[0] = 1'b1;
    tick();
    abort_v[0] = 1'b0;
    @(negedge clk);
    chk("abort_outputs_zero", (m == '0) ? 1 : 0, 1);
    repeat (12) tick();
    chk("abort_no_done", n_done, 0);
    chk("abort_issued_taps", n_iss, 501);
    run_full(1);

    // 6x6 map, 3x3 kernel
    select_cfg(1);
    tick();
    run_full(1);

    // 4x4 map, 1x1 kernel, read latency 3; results offered while idle must not write
    select_cfg(2);
    tick();
    n_wr = 0;
    inject = 1'b1;
    repeat (8) tick();
    inject = 1'b0;
    repeat (3) tick();
    chk("idle_qen_no_write", n_wr, 0);
    run_full(0);

    for (int i = 0; i < 9; i++) begin
      int key;
      key = vtab[i].cfg * 100000 + vtab[i].t;
      if (cap_img.exists(key)) begin
        chk("vec_img_rd_addr", cap_img[key], vtab[i].img);
        chk("vec_w_rd_addr", cap_w[key], vtab[i].w);
      end else begin
        chk("vec_tap_issued", 0, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
